// File: rtl/mem_access_ctrl_pkg.sv
// Shared op/state encodings and lane helpers for the data-RAM load/store controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LBU = 3'b001,
        OP_LH  = 3'b010,
        OP_LHU = 3'b011,
        OP_LW  = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic CE_ENABLE  = 1'b1;
    localparam logic CE_DISABLE = 1'b0;
    localparam logic WE_ENABLE  = 1'b1;
    localparam logic WE_DISABLE = 1'b0;
    localparam int   WAIT_W     = 4;

    function automatic logic is_store(input op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_half(input op_t op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input op_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input op_t op, input logic [1:0] lo);
        return (is_half(op) && lo[0]) || (is_word(op) && (lo != 2'b00));
    endfunction

    // Big-endian lanes: byte offset 0 sits in bits 31:24, i.e. sel[3].
    function automatic logic [3:0] lane_sel(input op_t op, input logic [1:0] lo);
        if (is_word(op))
            return 4'b1111;
        else if (is_half(op))
            return lo[1] ? 4'b0011 : 4'b1100;
        else
            return 4'b1000 >> lo;
    endfunction

    function automatic logic [31:0] store_data(input op_t op, input logic [31:0] wdata);
        case (op)
            OP_SB:   return {4{wdata[7:0]}};
            OP_SH:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Picks the addressed byte/halfword out of a RAM word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none.
module mem_access_ctrl_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  op_t         op,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[31:24];
        case (addr_lo)
            2'b00: byte_v = rdata[31:24];
            2'b01: byte_v = rdata[23:16];
            2'b10: byte_v = rdata[15:8];
            2'b11: byte_v = rdata[7:0];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        data = 32'h0;
        case (op)
            OP_LB:   data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  data = {24'h0, byte_v};
            OP_LH:   data = {{16{half_v[15]}}, half_v};
            OP_LHU:  data = {16'h0, half_v};
            OP_LW:   data = rdata;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator from the MEM stage to a word-organised data RAM, one access at a time.
// Latency: WAIT_CYCLES+2 cycles from acceptance to resp_valid; misaligned ops answer 1 cycle after.
// Backpressure: req_ready low and stall_req high while an access is in flight; requester holds req_valid.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall_req,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    op_t               op_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        sel_q;
    logic [31:0]       load_data;
    op_t               req_op_t;
    logic              req_misaligned;
    logic              last_access;

    assign req_op_t       = op_t'(req_op);
    assign req_misaligned = is_misaligned(req_op_t, req_addr[1:0]);
    assign last_access    = (state == ACCESS) && (wait_cnt == '0);

    mem_access_ctrl_load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_q[1:0]),
        .op      (op_q),
        .data    (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        stall_req  = 1'b0;
        resp_valid = 1'b0;
        mem_ce     = CE_DISABLE;
        mem_we     = WE_DISABLE;
        mem_sel    = 4'b0000;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                stall_req = req_valid;
                if (req_valid)
                    state_nxt = req_misaligned ? RESP : ACCESS;
            end
            ACCESS: begin
                stall_req = 1'b1;
                mem_ce    = CE_ENABLE;
                mem_sel   = sel_q;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = wdata_q;
                // Write only on the last wait cycle so the RAM sees a single write edge.
                if (last_access && is_store(op_q))
                    mem_we = WE_ENABLE;
                if (last_access)
                    state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= '0;
            op_q       <= OP_LB;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            sel_q      <= 4'b0000;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                op_q     <= req_op_t;
                addr_q   <= req_addr;
                wdata_q  <= store_data(req_op_t, req_wdata);
                sel_q    <= lane_sel(req_op_t, req_addr[1:0]);
                wait_cnt <= WAIT_INIT;
                if (req_misaligned) begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b1;
                end
            end else if (state == ACCESS) begin
                if (wait_cnt != '0) begin
                    wait_cnt <= wait_cnt - 1'b1;
                end else begin
                    resp_rdata <= is_store(op_q) ? 32'h0 : load_data;
                    resp_err   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES 0 and 3) each with a small RAM model.
// Stimulus pushes expected responses; a monitor pops and compares on every resp_valid.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst3;
    logic        tb_valid;
    logic [2:0]  tb_op;
    logic [31:0] tb_addr, tb_wdata;
    int          sel_d;

    logic        v0, rdy0, rv0, err0, st0, ce0, we0;
    logic [3:0]  sel0;
    logic [31:0] rd0, ma0, mw0, mr0;
    logic        v3, rdy3, rv3, err3, st3, ce3, we3;
    logic [3:0]  sel3;
    logic [31:0] rd3, ma3, mw3, mr3;

    assign v0 = tb_valid && (sel_d == 0);
    assign v3 = tb_valid && (sel_d == 1);

    mem_access_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .req_valid(v0), .req_ready(rdy0), .req_op(tb_op),
        .req_addr(tb_addr), .req_wdata(tb_wdata), .resp_valid(rv0), .resp_rdata(rd0),
        .resp_err(err0), .stall_req(st0), .mem_ce(ce0), .mem_we(we0), .mem_sel(sel0),
        .mem_addr(ma0), .mem_wdata(mw0), .mem_rdata(mr0)
    );

    mem_access_ctrl #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(v3), .req_ready(rdy3), .req_op(tb_op),
        .req_addr(tb_addr), .req_wdata(tb_wdata), .resp_valid(rv3), .resp_rdata(rd3),
        .resp_err(err3), .stall_req(st3), .mem_ce(ce3), .mem_we(we3), .mem_sel(sel3),
        .mem_addr(ma3), .mem_wdata(mw3), .mem_rdata(mr3)
    );

    logic [31:0] ram0 [64];
    logic [31:0] ram3 [64];
    assign mr0 = ram0[ma0[7:2]];
    assign mr3 = ram3[ma3[7:2]];

    always @(posedge clk) begin
        if (ce0 && we0)
            for (int i = 0; i < 4; i++)
                if (sel0[i]) ram0[ma0[7:2]][8*i +: 8] <= mw0[8*i +: 8];
        if (ce3 && we3)
            for (int i = 0; i < 4; i++)
                if (sel3[i]) ram3[ma3[7:2]][8*i +: 8] <= mw3[8*i +: 8];
    end

    logic        vw_ready, vw_rv, vw_stall, vw_ce, vw_we;
    logic [3:0]  vw_sel;
    logic [31:0] vw_wd;
    always_comb begin
        vw_ready = rdy0; vw_rv = rv0; vw_stall = st0; vw_ce = ce0; vw_we = we0;
        vw_sel = sel0; vw_wd = mw0;
        if (sel_d == 1) begin
            vw_ready = rdy3; vw_rv = rv3; vw_stall = st3; vw_ce = ce3; vw_we = we3;
            vw_sel = sel3; vw_wd = mw3;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t q0[$];
    exp_t q3[$];

    // Scoreboard monitor: any resp_valid without a pending expectation is itself a failure.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rv0 === 1'b1) begin
                if (q0.size() == 0) check("dut0 unexpected resp", {31'b0, rv0}, 32'h0);
                else begin
                    e = q0.pop_front();
                    check("dut0 resp_rdata", rd0, e.rd);
                    check("dut0 resp_err", {31'b0, err0}, {31'b0, e.err});
                end
            end
            if (rv3 === 1'b1) begin
                if (q3.size() == 0) check("dut3 unexpected resp", {31'b0, rv3}, 32'h0);
                else begin
                    e = q3.pop_front();
                    check("dut3 resp_rdata", rd3, e.rd);
                    check("dut3 resp_err", {31'b0, err3}, {31'b0, e.err});
                end
            end
        end
    end

    task automatic issue(input int d, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                         input logic [3:0] exp_sel, input logic [31:0] exp_wd, input string nm);
        int   w, lat, ce_n, we_n, we_pos, st_n;
        logic [3:0]  s_at_we;
        logic [31:0] wd_at_we;
        logic accepted, done;
        exp_t e;
        w = (d == 1) ? 3 : 0;
        lat = 0; ce_n = 0; we_n = 0; we_pos = 0; st_n = 0;
        s_at_we = 4'h0; wd_at_we = 32'h0; accepted = 1'b0; done = 1'b0;
        e.rd = exp_rd; e.err = exp_err;
        if (d == 1) q3.push_back(e); else q0.push_back(e);
        @(posedge clk); #1;
        sel_d = d; tb_op = op; tb_addr = addr; tb_wdata = wdata; tb_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (vw_stall) st_n++;
            if (vw_ready) accepted = 1'b1;
        end
        check({nm, " accepted"}, {31'b0, accepted}, 32'h1);
        @(posedge clk); #1;
        tb_valid = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (vw_stall) st_n++;
            if (vw_ce) ce_n++;
            if (vw_we) begin
                we_n++; we_pos = ce_n; s_at_we = vw_sel; wd_at_we = vw_wd;
            end
            if (vw_rv) done = 1'b1;
        end
        check({nm, " resp seen"}, {31'b0, done}, 32'h1);
        check({nm, " latency"}, lat, exp_err ? 1 : w + 2);
        check({nm, " ce cycles"}, ce_n, exp_err ? 0 : w + 1);
        check({nm, " stall cycles"}, st_n, exp_err ? 1 : w + 2);
        if (op >= 3'b101) begin
            check({nm, " we pulses"}, we_n, 1);
            check({nm, " we in last access"}, we_pos, w + 1);
            check({nm, " sel"}, {28'h0, s_at_we}, {28'h0, exp_sel});
            check({nm, " wdata"}, wd_at_we, exp_wd);
        end else begin
            check({nm, " no we"}, we_n, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_seen;
        rst0 = 1'b1; rst3 = 1'b1; tb_valid = 1'b0; sel_d = 0;
        tb_op = 3'b000; tb_addr = 32'h0; tb_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("reset req_ready", {31'b0, rdy0}, 32'h1);
        check("reset resp_valid", {31'b0, rv0}, 32'h0);
        check("reset resp_rdata", rd0, 32'h0);
        check("reset resp_err", {31'b0, err0}, 32'h0);
        check("reset ce/we", {30'b0, ce0, we0}, 32'h0);
        check("reset mem_sel", {28'h0, sel0}, 32'h0);
        check("reset mem_addr", ma0, 32'h0);
        check("reset mem_wdata", mw0, 32'h0);
        check("reset dut3 ready/ce", {30'b0, rdy3, ce3}, 32'h2);
        rst0 = 1'b0; rst3 = 1'b0;

        issue(0, OP_SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF, "SW 0x10");
        issue(0, OP_LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 4'h0, 32'h0, "LW 0x10");
        issue(0, OP_SB,  32'h13, 32'h80,       32'h0,        1'b0, 4'b0001, 32'h80808080, "SB 0x13");
        issue(0, OP_LB,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 4'h0, 32'h0, "LB 0x13");
        issue(0, OP_LBU, 32'h13, 32'h0,        32'h00000080, 1'b0, 4'h0, 32'h0, "LBU 0x13");
        issue(0, OP_LB,  32'h10, 32'h0,        32'hFFFFFFDE, 1'b0, 4'h0, 32'h0, "LB 0x10");
        issue(0, OP_SW,  32'h20, 32'hFFFF0000, 32'h0,        1'b0, 4'b1111, 32'hFFFF0000, "SW 0x20");
        issue(0, OP_SH,  32'h22, 32'h8001,     32'h0,        1'b0, 4'b0011, 32'h80018001, "SH 0x22");
        issue(0, OP_LH,  32'h20, 32'h0,        32'hFFFFFFFF, 1'b0, 4'h0, 32'h0, "LH 0x20");
        issue(0, OP_LHU, 32'h22, 32'h0,        32'h00008001, 1'b0, 4'h0, 32'h0, "LHU 0x22");
        issue(0, OP_LH,  32'h22, 32'h0,        32'hFFFF8001, 1'b0, 4'h0, 32'h0, "LH 0x22");
        issue(0, OP_LW,  32'h06, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0, "LW 0x06 misaligned");
        issue(0, OP_LH,  32'h21, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0, "LH 0x21 misaligned");
        issue(0, OP_LW,  32'h10, 32'h0,        32'hDEADBE80, 1'b0, 4'h0, 32'h0, "LW 0x10 after SB");

        issue(1, OP_SW,  32'h40, 32'hAAAA5555, 32'h0,        1'b0, 4'b1111, 32'hAAAA5555, "W3 SW 0x40");
        issue(1, OP_LW,  32'h40, 32'h0,        32'hAAAA5555, 1'b0, 4'h0, 32'h0, "W3 LW 0x40");

        // Abort a store mid-access with reset; the RAM word must be untouched and no response produced.
        @(posedge clk); #1;
        sel_d = 1; tb_op = OP_SW; tb_addr = 32'h40; tb_wdata = 32'h12345678; tb_valid = 1'b1;
        @(negedge clk);
        check("abort accept ready", {31'b0, rdy3}, 32'h1);
        @(posedge clk); #1;
        tb_valid = 1'b0;
        @(negedge clk);
        check("abort in access", {30'b0, ce3, we3}, 32'h2);
        rst3 = 1'b1;
        #1;
        check("abort async ce/we", {30'b0, ce3, we3}, 32'h0);
        check("abort ready/resp", {30'b0, rdy3, rv3}, 32'h2);
        check("abort sel", {28'h0, sel3}, 32'h0);
        we_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (we3) we_seen++;
        end
        check("abort we during reset", we_seen, 0);
        rst3 = 1'b0;
        issue(1, OP_LW,  32'h40, 32'h0,        32'hAAAA5555, 1'b0, 4'h0, 32'h0, "W3 LW after abort");

        repeat (3) @(negedge clk);
        check("scoreboard drained", q0.size() + q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
